mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous word memory between two requesters: instruction fetch (port I, read-only) and data load/store (port D, read/write).
- Sits between the core pipeline and the 32-bit memory model.
- The memory registers its read data: a read issued at clock edge N returns data after edge N.
- Arbitration is data-priority with a starvation guard for fetch. Read data is routed back to the issuing port with a one-cycle valid strobe.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles port I may be requesting and denied before it is forced to win. Range 1..15.
- ADDR_W, 32: address width. Memory address output is word-aligned.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- i_req_i  input  1  port I read request.
- i_addr_i  input  ADDR_W  port I byte address.
- i_gnt_o  output  1  port I request accepted this cycle (combinational).
- i_rvalid_o  output  1  port I read data valid (registered).
- i_rdata_o  output  32  port I read data.
- d_req_i  input  1  port D request.
- d_we_i  input  1  port D: 1 = write, 0 = read.
- d_addr_i  input  ADDR_W  port D byte address.
- d_wdata_i  input  32  port D write data.
- d_gnt_o  output  1  port D request accepted this cycle (combinational).
- d_rvalid_o  output  1  port D read data valid (registered).
- d_rdata_o  output  32  port D read data.
- mem_wen_o  output  1  memory write enable.
- mem_addr_o  output  ADDR_W  memory byte address.
- mem_wdata_o  output  32  memory write data.
- mem_rdata_i  input  32  memory read data (one-cycle latency).

Behaviour:
- Reset: rst_n_i low asynchronously clears:
  - starve_cnt = 0
  - rd_pend = 0, rd_owner = I
  - i_rvalid_o = d_rvalid_o = 0
  - an outstanding read is discarded; no rvalid is produced after reset deasserts.
- Grant logic (combinational, same cycle as req):
  - Only d_req_i: D wins.
  - Only i_req_i: I wins.
  - Both, starve_cnt < STARVE_LIMIT: D wins.
  - Both, starve_cnt == STARVE_LIMIT: I wins.
  - Neither: no grant.
  - At most one of i_gnt_o/d_gnt_o is high in any cycle.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) when i_req_i=1 and i_gnt_o=0.
  - Clears to 0 whenever i_gnt_o=1 or i_req_i=0.
- Memory drive:
  - mem_addr_o = winner address with bits [1:0] forced to 0.
  - mem_wen_o = d_gnt_o & d_we_i.
  - mem_wdata_o = d_wdata_i.
  - No grant: mem_wen_o=0, mem_addr_o = all-zero, mem_wdata_o = 0 (a harmless read).
- Read return:
  - At the edge ending a granted read, set rd_pend=1 and record rd_owner; otherwise rd_pend=0.
  - i_rvalid_o = rd_pend & (rd_owner==I); d_rvalid_o = rd_pend & (rd_owner==D).
  - Both rdata outputs equal mem_rdata_i. Data is meaningful only while the matching rvalid is high.
- Writes: complete at the grant edge. No rvalid is generated.
- Throughput and ordering:
  - One access per cycle. Back-to-back grants are allowed: a new read may be granted in the cycle its predecessor's rvalid is high.
  - Returns come back in issue order, exactly one cycle after grant.
- Requesters hold req/addr/wdata/we stable until gnt is seen. The arbiter does not buffer requests.
- A write and a read to the same address in consecutive cycles: the read returns the newly written data.

Test Plan:
- Reset mid-read: I read to 0x10 granted, rst_n_i pulsed low before the next edge -> i_rvalid_o=0, both gnt=0, starve_cnt=0 after release.
- Solo fetch: memory word[4]=0xDEADBEEF; i_req_i=1, i_addr_i=0x13 -> i_gnt_o=1 same cycle, mem_addr_o=0x10; next cycle i_rvalid_o=1, i_rdata_o=0xDEADBEEF, d_rvalid_o=0.
- Data write then read: D write 0x12345678 to 0x20, then D read 0x20 next cycle -> mem_wen_o=1 only in the first cycle; d_rvalid_o=1 with 0x12345678 one cycle after the read grant.
- Contention: both req held continuously, STARVE_LIMIT=4 -> grant pattern D,D,D,D,I repeating. i_gnt_o is high in exactly the 5th cycle. Never both gnt high.
- Back-to-back alternation: I read 0x0 then D read 0x4 in consecutive cycles (memory 0x11, 0x22) -> i_rvalid_o/0x11 then d_rvalid_o/0x22 in successive cycles; never both valid together.
- Idle: no requests for 10 cycles -> mem_wen_o=0, no rvalid, starve_cnt stays 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters (fetch I, load/store D), the arbiter and the word memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              i_req_i;
    logic [ADDR_W-1:0] i_addr_i;
    logic              i_gnt_o;
    logic              i_rvalid_o;
    logic [31:0]       i_rdata_o;

    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [31:0]       d_wdata_i;
    logic              d_gnt_o;
    logic              d_rvalid_o;
    logic [31:0]       d_rdata_o;

    logic              mem_wen_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;

    modport slave (
        input  i_req_i, i_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i,
        output i_gnt_o, i_rvalid_o, i_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
               mem_wen_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output i_req_i, i_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i,
        input  i_gnt_o, i_rvalid_o, i_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
               mem_wen_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Data-priority arbiter for a single-port synchronous memory shared by fetch (I) and load/store (D),
// with a starvation guard for fetch and one-cycle read-return routing.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    mem_port_arbiter_if.slave  bus
);
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             rd_pend_q, rd_pend_d;
    owner_e           rd_owner_q, rd_owner_d;

    logic              i_gnt_s;
    logic              d_gnt_s;
    logic              rd_issue_s;
    logic              mem_wen_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [31:0]       mem_wdata_s;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

    // Grant selection: D wins unless fetch has been denied STARVE_LIMIT cycles in a row.
    always_comb begin
        i_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
        if (bus.d_req_i && bus.i_req_i) begin
            if (starve_cnt_q == LIMIT) begin
                i_gnt_s = 1'b1;
            end else begin
                d_gnt_s = 1'b1;
            end
        end else if (bus.d_req_i) begin
            d_gnt_s = 1'b1;
        end else if (bus.i_req_i) begin
            i_gnt_s = 1'b1;
        end else begin
            i_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end
    end

    // Memory drive; an idle cycle issues a harmless read of address zero.
    always_comb begin
        mem_wen_s   = 1'b0;
        mem_addr_s  = '0;
        mem_wdata_s = 32'h0000_0000;
        if (d_gnt_s) begin
            mem_wen_s   = bus.d_we_i;
            mem_addr_s  = word_align(bus.d_addr_i);
            mem_wdata_s = bus.d_wdata_i;
        end else if (i_gnt_s) begin
            mem_addr_s  = word_align(bus.i_addr_i);
            mem_wdata_s = bus.d_wdata_i;
        end else begin
            mem_wen_s   = 1'b0;
            mem_addr_s  = '0;
            mem_wdata_s = 32'h0000_0000;
        end
    end

    assign rd_issue_s = i_gnt_s | (d_gnt_s & ~bus.d_we_i);

    // Next-state for the starvation counter and the pending-read tracker.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        rd_pend_d    = rd_issue_s;
        rd_owner_d   = rd_owner_q;
        if (bus.i_req_i && !i_gnt_s) begin
            if (starve_cnt_q == LIMIT) begin
                starve_cnt_d = starve_cnt_q;
            end else begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end else begin
            starve_cnt_d = 4'd0;
        end
        if (rd_issue_s) begin
            rd_owner_d = i_gnt_s ? OWNER_I : OWNER_D;
        end else begin
            rd_owner_d = rd_owner_q;
        end
    end

    // State registers; reset also drops any read still in flight.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            starve_cnt_q <= 4'd0;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= OWNER_I;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    assign bus.i_gnt_o     = i_gnt_s;
    assign bus.d_gnt_o     = d_gnt_s;
    assign bus.mem_wen_o   = mem_wen_s;
    assign bus.mem_addr_o  = mem_addr_s;
    assign bus.mem_wdata_o = mem_wdata_s;
    assign bus.i_rvalid_o  = rd_pend_q & (rd_owner_q == OWNER_I);
    assign bus.d_rvalid_o  = rd_pend_q & (rd_owner_q == OWNER_D);
    assign bus.i_rdata_o   = bus.mem_rdata_i;
    assign bus.d_rdata_o   = bus.mem_rdata_i;
endmodule
